// File: rtl/tpu_pkg.sv
// Shared definitions for the tiled-matmul sequencer.
//   state_t            : sequencer FSM states
//   drain_lat_default  : default skew/drain latency for an ARR x ARR array
//   aw_fits            : address width large enough for K*max(Mseg,Nseg)-style products
//   sel_width          : width of a row selector for ARR rows (at least 1 bit)
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  // The last A/B word needs one SRAM cycle plus 2*ARR-2 skew hops to
  // reach the far corner PE.
  function automatic int drain_lat_default(input int arr);
    return 2 * arr - 1;
  endfunction

  function automatic bit aw_fits(input int aw, input int dimw);
    return aw >= 2 * dimw;
  endfunction

  function automatic int sel_width(input int arr);
    return (arr > 1) ? $clog2(arr) : 1;
  endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Bundle between the tile sequencer and its surroundings.
//   Host side : start, K, M, N, order, abort -> busy, done, err
//   SRAM side : A_rd_en/A_addr, B_rd_en/B_addr, C_wr_en/C_addr
//   Array side: arr_clear, arr_feed, arr_row_sel
// master = the sequencer, slave = host/SRAM/array environment.
interface tpu_tile_sequencer_if #(
  parameter int ARR  = 4,
  parameter int DIMW = 8,
  parameter int AW   = 16
);
  import tpu_pkg::*;

  localparam int RSW = sel_width(ARR);

  logic            start;
  logic [DIMW-1:0] K;
  logic [DIMW-1:0] M;
  logic [DIMW-1:0] N;
  logic            order;
  logic            abort;
  logic            busy;
  logic            done;
  logic            err;
  logic            A_rd_en;
  logic [AW-1:0]   A_addr;
  logic            B_rd_en;
  logic [AW-1:0]   B_addr;
  logic            arr_clear;
  logic            arr_feed;
  logic [RSW-1:0]  arr_row_sel;
  logic            C_wr_en;
  logic [AW-1:0]   C_addr;

  modport master (
    input  start, K, M, N, order, abort,
    output busy, done, err,
    output A_rd_en, A_addr, B_rd_en, B_addr,
    output arr_clear, arr_feed, arr_row_sel,
    output C_wr_en, C_addr
  );

  modport slave (
    output start, K, M, N, order, abort,
    input  busy, done, err,
    input  A_rd_en, A_addr, B_rd_en, B_addr,
    input  arr_clear, arr_feed, arr_row_sel,
    input  C_wr_en, C_addr
  );

endinterface

// File: rtl/tpu_tile_iter.sv
// Tile iterator: walks the (a,b) tile grid and keeps the SRAM base
// addresses in step using additions only.
//   clk, rst_n   : clock, async active-low reset
//   init         : return to tile (0,0) with all bases 0
//   advance      : step to the next tile
//   order        : 0 = a fastest, 1 = b fastest
//   k_dim        : K (A/B base stride per tile)
//   m_seg, n_seg : number of tiles along M and N
//   m_pad        : Mseg*ARR, C column-block stride
//   a_base, b_base, c_rowofs, c_colbase : a*K, b*K, a*ARR, b*Mseg*ARR
//   last_tile    : current tile is the final one
module tpu_tile_iter #(
  parameter int ARR  = 4,
  parameter int DIMW = 8,
  parameter int AW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          advance,
  input  logic          order,
  input  logic [DIMW-1:0] k_dim,
  input  logic [DIMW:0] m_seg,
  input  logic [DIMW:0] n_seg,
  input  logic [AW-1:0] m_pad,
  output logic [AW-1:0] a_base,
  output logic [AW-1:0] b_base,
  output logic [AW-1:0] c_rowofs,
  output logic [AW-1:0] c_colbase,
  output logic          last_tile
);

  logic [DIMW:0] a_idx;
  logic [DIMW:0] b_idx;
  logic          a_wrap;
  logic          b_wrap;
  logic [AW-1:0] k_step;

  assign k_step    = AW'(k_dim);
  assign a_wrap    = (a_idx == m_seg - (DIMW+1)'(1));
  assign b_wrap    = (b_idx == n_seg - (DIMW+1)'(1));
  assign last_tile = a_wrap && b_wrap;

  // Tile counters and their base registers move together: the fast index
  // wraps to 0 (clearing its bases) and the slow index steps by one stride.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_idx     <= '0;
      b_idx     <= '0;
      a_base    <= '0;
      b_base    <= '0;
      c_rowofs  <= '0;
      c_colbase <= '0;
    end else if (init) begin
      a_idx     <= '0;
      b_idx     <= '0;
      a_base    <= '0;
      b_base    <= '0;
      c_rowofs  <= '0;
      c_colbase <= '0;
    end else if (advance) begin
      if (!order) begin
        if (a_wrap) begin
          a_idx     <= '0;
          a_base    <= '0;
          c_rowofs  <= '0;
          b_idx     <= b_idx + (DIMW+1)'(1);
          b_base    <= b_base + k_step;
          c_colbase <= c_colbase + m_pad;
        end else begin
          a_idx    <= a_idx + (DIMW+1)'(1);
          a_base   <= a_base + k_step;
          c_rowofs <= c_rowofs + AW'(ARR);
        end
      end else begin
        if (b_wrap) begin
          b_idx     <= '0;
          b_base    <= '0;
          c_colbase <= '0;
          a_idx     <= a_idx + (DIMW+1)'(1);
          a_base    <= a_base + k_step;
          c_rowofs  <= c_rowofs + AW'(ARR);
        end else begin
          b_idx     <= b_idx + (DIMW+1)'(1);
          b_base    <= b_base + k_step;
          c_colbase <= c_colbase + m_pad;
        end
      end
    end
  end

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Tiled matmul controller for an ARR x ARR output-stationary array.
// Per tile: clear, K feed reads of A/B, DRAIN_LAT wait, ARR C row writes.
//   clk, rst_n : clock, async active-low reset
//   bus        : host handshake, A/B/C SRAM ports and array controls
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int ARR       = 4,
  parameter int DIMW      = 8,
  parameter int AW        = 16,
  parameter int DRAIN_LAT = drain_lat_default(ARR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tpu_tile_sequencer_if.master bus
);

  localparam int RSW = sel_width(ARR);
  localparam int CW  = DIMW + $clog2(ARR + DRAIN_LAT + 1);

  if (!aw_fits(AW, DIMW)) begin : g_aw_check
    $error("tpu_tile_sequencer: AW must be at least 2*DIMW");
  end

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic [DIMW-1:0] k_dim;
  logic [DIMW:0]   m_seg;
  logic [DIMW:0]   n_seg;
  logic [AW-1:0]   m_pad;
  logic            order_q;
  logic            err_q;
  logic            feed_q;

  logic [DIMW:0]   m_round;
  logic [DIMW:0]   n_round;
  logic [DIMW:0]   m_seg_w;
  logic [DIMW:0]   n_seg_w;
  logic            start_ok;
  logic            zero_dim;
  logic            in_busy;
  logic [CW-1:0]   k_last;

  logic [AW-1:0]   a_base;
  logic [AW-1:0]   b_base;
  logic [AW-1:0]   c_rowofs;
  logic [AW-1:0]   c_colbase;
  logic            last_tile;

  // Ceiling division by the constant array size; partial edge tiles are padded.
  assign m_round  = {1'b0, bus.M} + (DIMW+1)'(ARR - 1);
  assign n_round  = {1'b0, bus.N} + (DIMW+1)'(ARR - 1);
  assign m_seg_w  = m_round / (DIMW+1)'(ARR);
  assign n_seg_w  = n_round / (DIMW+1)'(ARR);

  assign start_ok = (state_q == S_IDLE) && bus.start;
  assign zero_dim = (k_dim == '0) || (m_seg == '0) || (n_seg == '0);
  assign in_busy  = (state_q == S_LOAD) || (state_q == S_FEED) || (state_q == S_DRAIN) ||
                    (state_q == S_WRITE) || (state_q == S_NEXT);
  assign k_last   = CW'(k_dim) - CW'(1);

  tpu_tile_iter #(
    .ARR  (ARR),
    .DIMW (DIMW),
    .AW   (AW)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (state_q == S_LOAD),
    .advance   (state_q == S_NEXT),
    .order     (order_q),
    .k_dim     (k_dim),
    .m_seg     (m_seg),
    .n_seg     (n_seg),
    .m_pad     (m_pad),
    .a_base    (a_base),
    .b_base    (b_base),
    .c_rowofs  (c_rowofs),
    .c_colbase (c_colbase),
    .last_tile (last_tile)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Job parameters are latched on an accepted start; err is sticky and only
  // cleared there. An abort in LOAD leaves err untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_dim   <= '0;
      m_seg   <= '0;
      n_seg   <= '0;
      m_pad   <= '0;
      order_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (start_ok) begin
      k_dim   <= bus.K;
      m_seg   <= m_seg_w;
      n_seg   <= n_seg_w;
      // Constant scale by the array size, computed once per job.
      m_pad   <= AW'(m_seg_w) * AW'(ARR);
      order_q <= bus.order;
      err_q   <= 1'b0;
    end else if ((state_q == S_LOAD) && zero_dim && !bus.abort) begin
      err_q   <= 1'b1;
    end
  end

  // One shared phase counter (k, drain, r); it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_d != state_q) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  // SRAM data lands one cycle after the read; the abort gate keeps every
  // enable low from the cycle after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) feed_q <= 1'b0;
    else        feed_q <= (state_q == S_FEED) && !bus.abort;
  end

  // Next-state logic; abort overrides everything in the busy states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = zero_dim ? S_DONE : S_FEED;
      S_FEED:  if (cnt == k_last) state_d = S_DRAIN;
      S_DRAIN: if (cnt == CW'(DRAIN_LAT - 1)) state_d = S_WRITE;
      S_WRITE: if (cnt == CW'(ARR - 1)) state_d = last_tile ? S_DONE : S_NEXT;
      S_NEXT:  state_d = S_FEED;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (in_busy && bus.abort) state_d = S_IDLE;
  end

  // Moore outputs; addresses are held at 0 whenever their enable is low.
  always_comb begin
    bus.busy        = in_busy;
    bus.done        = 1'b0;
    bus.A_rd_en     = 1'b0;
    bus.A_addr      = '0;
    bus.B_rd_en     = 1'b0;
    bus.B_addr      = '0;
    bus.arr_clear   = 1'b0;
    bus.arr_row_sel = '0;
    bus.C_wr_en     = 1'b0;
    bus.C_addr      = '0;
    unique case (state_q)
      S_LOAD:  bus.arr_clear = !zero_dim;
      S_FEED: begin
        bus.A_rd_en = 1'b1;
        bus.B_rd_en = 1'b1;
        bus.A_addr  = a_base + AW'(cnt);
        bus.B_addr  = b_base + AW'(cnt);
      end
      S_WRITE: begin
        bus.C_wr_en     = 1'b1;
        bus.arr_row_sel = cnt[RSW-1:0];
        bus.C_addr      = c_colbase + c_rowofs + AW'(cnt);
      end
      S_NEXT:  bus.arr_clear = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.err      = err_q;
  assign bus.arr_feed = feed_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer with ARR=4, DIMW=8, AW=16, DRAIN_LAT=7.
// Job vectors carry hand-computed tile bases and done cycles; every cycle
// of a job is compared against a cycle model built from those values.
module tb_tpu_tile_sequencer;

  localparam int ARR  = 4;
  localparam int DIMW = 8;
  localparam int AW   = 16;
  localparam int DL   = 7;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        a_en;
    logic [15:0] a_addr;
    logic        b_en;
    logic [15:0] b_addr;
    logic        clr;
    logic        feed;
    logic [1:0]  row;
    logic        c_en;
    logic [15:0] c_addr;
  } obs_t;

  typedef struct packed {
    logic [7:0]      k;
    logic [7:0]      m;
    logic [7:0]      n;
    logic            order;
    logic [3:0]      ntiles;
    logic [7:0]      done_cyc;
    logic            err;
    logic [3:0][7:0] a_run;
    logic [3:0][7:0] b_run;
    logic [3:0][7:0] c_run;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.ARR(ARR), .DIMW(DIMW), .AW(AW)) bus();

  tpu_tile_sequencer #(
    .ARR       (ARR),
    .DIMW      (DIMW),
    .AW        (AW),
    .DRAIN_LAT (DL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0][7:0] runs(input int r0, input int r1, input int r2, input int r3);
    logic [3:0][7:0] r;
    r[0] = 8'(r0);
    r[1] = 8'(r1);
    r[2] = 8'(r2);
    r[3] = 8'(r3);
    return r;
  endfunction

  function automatic vec_t mk_vec(input int k, input int m, input int n, input int o,
                                  input int nt, input int dc, input int e,
                                  input logic [3:0][7:0] ar, input logic [3:0][7:0] br,
                                  input logic [3:0][7:0] cr);
    vec_t v;
    v.k = 8'(k);
    v.m = 8'(m);
    v.n = 8'(n);
    v.order = 1'(o);
    v.ntiles = 4'(nt);
    v.done_cyc = 8'(dc);
    v.err = 1'(e);
    v.a_run = ar;
    v.b_run = br;
    v.c_run = cr;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.busy   = bus.busy;
    s.done   = bus.done;
    s.a_en   = bus.A_rd_en;
    s.a_addr = bus.A_addr;
    s.b_en   = bus.B_rd_en;
    s.b_addr = bus.B_addr;
    s.clr    = bus.arr_clear;
    s.feed   = bus.arr_feed;
    s.row    = bus.arr_row_sel;
    s.c_en   = bus.C_wr_en;
    s.c_addr = bus.C_addr;
    return s;
  endfunction

  // Cycle n counts from 1 = first cycle after the start edge. Each tile is
  // 1 clear cycle, K feed, DL drain and ARR write cycles.
  function automatic obs_t expect_obs(input vec_t v, input int n);
    obs_t e;
    int   k;
    int   per;
    int   t;
    int   ph;
    e   = '0;
    k   = int'(v.k);
    per = 1 + k + DL + ARR;
    if (v.err) begin
      if (n == 1) e.busy = 1'b1;
      else if (n == 2) e.done = 1'b1;
      return e;
    end
    if (n == int'(v.done_cyc)) begin
      e.done = 1'b1;
      return e;
    end
    if (n >= 1 && n < int'(v.done_cyc)) begin
      t  = (n - 1) / per;
      ph = (n - 1) % per;
      e.busy = 1'b1;
      if (ph == 0) e.clr = 1'b1;
      if (ph >= 1 && ph <= k) begin
        e.a_en   = 1'b1;
        e.b_en   = 1'b1;
        e.a_addr = 16'(v.a_run[t]) + 16'(ph - 1);
        e.b_addr = 16'(v.b_run[t]) + 16'(ph - 1);
      end
      if (ph >= 2 && ph <= k + 1) e.feed = 1'b1;
      if (ph >= k + 1 + DL) begin
        e.c_en   = 1'b1;
        e.row    = 2'(ph - k - 1 - DL);
        e.c_addr = 16'(v.c_run[t]) + 16'(ph - k - 1 - DL);
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic issueStart(input int k, input int m, input int n, input int o, input logic ab);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = ab;
    bus.K     = 8'(k);
    bus.M     = 8'(m);
    bus.N     = 8'(n);
    bus.order = 1'(o);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Runs one job from the table and checks every cycle through one idle
  // cycle after done.
  task automatic applyStimulus(input vec_t v, input int idx);
    int last;
    last = int'(v.done_cyc) + 1;
    issueStart(int'(v.k), int'(v.m), int'(v.n), int'(v.order), 1'b0);
    for (int n = 1; n <= last; n++) begin
      checkOutput($sformatf("vec%0d cyc%0d outputs", idx, n), 64'(sample()), 64'(expect_obs(v, n)));
      if (n == 1) checkOutput($sformatf("vec%0d err cleared on start", idx), 64'(bus.err), 64'(0));
      if (n >= int'(v.done_cyc))
        checkOutput($sformatf("vec%0d cyc%0d err", idx, n), 64'(bus.err), 64'(v.err));
      if (n < last) @(negedge clk);
    end
  endtask

  // Waits a number of cycles and checks that no done pulse and no busy appear.
  task automatic expectQuiet(input string name, input int cycles);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busys++;
    end
    checkOutput({name, " done pulses"}, 64'(dones), 64'(0));
    checkOutput({name, " busy cycles"}, 64'(busys), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.K     = '0;
    bus.M     = '0;
    bus.N     = '0;
    bus.order = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = mk_vec(3, 4, 4, 0, 1, 16, 0, runs(0, 0, 0, 0),  runs(0, 0, 0, 0),  runs(0, 0, 0, 0));
    vecs[1] = mk_vec(2, 8, 8, 0, 4, 57, 0, runs(0, 2, 0, 2),  runs(0, 0, 2, 2),  runs(0, 4, 8, 12));
    vecs[2] = mk_vec(2, 8, 8, 1, 4, 57, 0, runs(0, 0, 2, 2),  runs(0, 2, 0, 2),  runs(0, 8, 4, 12));
    vecs[3] = mk_vec(1, 5, 3, 0, 2, 27, 0, runs(0, 1, 0, 0),  runs(0, 0, 0, 0),  runs(0, 4, 0, 0));
    vecs[4] = mk_vec(0, 4, 4, 0, 0, 2,  1, runs(0, 0, 0, 0),  runs(0, 0, 0, 0),  runs(0, 0, 0, 0));
    vecs[5] = mk_vec(2, 4, 0, 0, 0, 2,  1, runs(0, 0, 0, 0),  runs(0, 0, 0, 0),  runs(0, 0, 0, 0));
    vecs[6] = mk_vec(1, 3, 9, 1, 3, 40, 0, runs(0, 0, 0, 0),  runs(0, 1, 2, 0),  runs(0, 4, 8, 0));

    #2;
    checkOutput("reset outputs", 64'(sample()), 64'(0));
    checkOutput("reset err", 64'(bus.err), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // start+abort together in IDLE: accepted. Later starts while busy and
    // in DONE are ignored, even with a different K on the bus.
    issueStart(3, 4, 4, 0, 1'b1);
    for (int n = 1; n <= 18; n++) begin
      checkOutput($sformatf("ignore-start cyc%0d outputs", n), 64'(sample()), 64'(expect_obs(vecs[0], n)));
      if (n == 3) begin
        bus.start = 1'b1;
        bus.K     = 8'd9;
      end
      if (n == 4 || n == 17) bus.start = 1'b0;
      if (n == 16) bus.start = 1'b1;
      if (n < 18) @(negedge clk);
    end

    // Abort in the DRAIN of the second tile.
    issueStart(2, 8, 8, 0, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      checkOutput($sformatf("abort-drain cyc%0d outputs", n), 64'(sample()), 64'(expect_obs(vecs[1], n)));
      if (n < 20) @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort-drain next cycle outputs", 64'(sample()), 64'(0));
    checkOutput("abort-drain err", 64'(bus.err), 64'(0));
    expectQuiet("abort-drain", 20);

    // Abort in the first FEED cycle: arr_feed must not follow the last read.
    issueStart(3, 4, 4, 0, 1'b0);
    @(negedge clk);
    checkOutput("abort-feed pre outputs", 64'(sample()), 64'(expect_obs(vecs[0], 2)));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort-feed next cycle outputs", 64'(sample()), 64'(0));
    expectQuiet("abort-feed", 20);

    // Reset asserted in the middle of FEED, between clock edges.
    issueStart(3, 4, 4, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset-feed pre outputs", 64'(sample()), 64'(expect_obs(vecs[0], 3)));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset-feed async outputs", 64'(sample()), 64'(0));
    checkOutput("reset-feed async err", 64'(bus.err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    expectQuiet("reset-feed", 20);

    applyStimulus(vecs[3], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
